// File: rtl/ci_issuer.sv
// ci_issuer: initiator side of the CORDIC custom-instruction handshake.
// Issues credit-limited CI ops and queues tagged results for the host.
module ci_issuer #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int RSP_DEPTH       = 4,
    parameter int ISSUE_GAP       = 1,
    parameter int TIMEOUT         = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [31:0]                      req_a,
    input  logic [31:0]                      req_b,
    input  logic [1:0]                       req_n,
    output logic                             ci_clk_en,
    output logic                             ci_start,
    output logic [31:0]                      ci_dataa,
    output logic [31:0]                      ci_datab,
    output logic [1:0]                       ci_n,
    input  logic [31:0]                      ci_result,
    input  logic                             ci_done,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [31:0]                      rsp_data,
    output logic [1:0]                       rsp_n,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
    output logic                             err_timeout,
    output logic                             err_spurious,
    input  logic                             clear_err
);

    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int FW = $clog2(RSP_DEPTH);
    localparam int CW = $clog2(RSP_DEPTH) + 1;
    localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [OW-1:0] OUT_MAX  = OW'(MAX_OUTSTANDING);
    localparam logic [QW-1:0] Q_LAST   = QW'(MAX_OUTSTANDING - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(ISSUE_GAP - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_ERROR
    } state_t;

    state_t state, state_nx;

    logic          issue, done_acc, spurious;
    logic          flush, pop, credit, tmo_hit;
    logic [31:0]   occupancy;
    logic [GW-1:0] gap_cnt;
    logic [TW-1:0] tcnt;

    logic [1:0]    tq_mem [MAX_OUTSTANDING];
    logic [QW-1:0] tq_wr, tq_rd;

    logic [33:0]   fifo_mem [RSP_DEPTH];
    logic [FW-1:0] f_wr, f_rd;
    logic [CW-1:0] fifo_count;

    function automatic logic [QW-1:0] q_next(input logic [QW-1:0] p);
        return (p == Q_LAST) ? '0 : p + QW'(1);
    endfunction

    // Results already queued or in flight both consume a FIFO slot,
    // so an unstallable done always finds room.
    assign occupancy = 32'(outstanding) + 32'(fifo_count);
    assign credit    = (outstanding < OUT_MAX)
                     & (occupancy < 32'(RSP_DEPTH))
                     & (gap_cnt == '0);
    assign req_ready = (state == S_RUN) & credit;
    assign ci_clk_en = (state != S_INIT);

    assign issue    = req_valid & req_ready;
    assign done_acc = ci_done & (outstanding != '0) & (state != S_ERROR);
    assign spurious = ci_done & (outstanding == '0) & (state != S_ERROR);
    assign flush    = (state == S_ERROR) & clear_err;
    assign pop      = rsp_valid & rsp_ready;
    assign tmo_hit  = (state == S_RUN) & (outstanding != '0)
                    & ~issue & ~done_acc & (tcnt == T_LAST);

    assign rsp_valid       = (fifo_count != '0);
    assign {rsp_n, rsp_data} = rsp_valid ? fifo_mem[f_rd] : '0;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_INIT;
        else     state <= state_nx;
    end

    // Next-state logic: INIT lasts one clock, ERROR waits for clear_err
    always_comb begin
        state_nx = state;
        unique case (state)
            S_INIT:  state_nx = S_RUN;
            S_RUN:   if (tmo_hit) state_nx = S_ERROR;
            S_ERROR: if (clear_err) state_nx = S_RUN;
            default: state_nx = S_INIT;
        endcase
    end

    // Start pulse and operand registers held until the next issue
    always_ff @(posedge clk) begin
        if (rst) begin
            ci_start <= 1'b0;
            ci_dataa <= '0;
            ci_datab <= '0;
            ci_n     <= '0;
        end else begin
            ci_start <= issue;
            if (issue) begin
                ci_dataa <= req_a;
                ci_datab <= req_b;
                ci_n     <= req_n;
            end
        end
    end

    // Minimum spacing between start pulses
    always_ff @(posedge clk) begin
        if (rst)                  gap_cnt <= '0;
        else if (issue)           gap_cnt <= GAP_LOAD;
        else if (gap_cnt != '0)   gap_cnt <= gap_cnt - GW'(1);
    end

    // In-flight op count; a same-edge issue and done cancel out
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            outstanding <= '0;
        end else begin
            case ({issue, done_acc})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Tag queue: n of each in-flight op in issue order
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            tq_wr <= '0;
            tq_rd <= '0;
        end else begin
            if (issue) begin
                tq_mem[tq_wr] <= req_n;
                tq_wr         <= q_next(tq_wr);
            end
            if (done_acc) tq_rd <= q_next(tq_rd);
        end
    end

    // Response FIFO; survives ERROR and clear_err
    always_ff @(posedge clk) begin
        if (rst) begin
            f_wr       <= '0;
            f_rd       <= '0;
            fifo_count <= '0;
        end else begin
            if (done_acc) begin
                fifo_mem[f_wr] <= {tq_mem[tq_rd], ci_result};
                f_wr           <= f_wr + FW'(1);
            end
            if (pop) f_rd <= f_rd + FW'(1);
            case ({done_acc, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Idle watchdog while ops are outstanding
    always_ff @(posedge clk) begin
        if (rst)
            tcnt <= '0;
        else if (state != S_RUN || outstanding == '0
                 || issue || done_acc || tmo_hit)
            tcnt <= '0;
        else
            tcnt <= tcnt + TW'(1);
    end

    // Sticky error flags; a new event wins over a same-edge clear
    always_ff @(posedge clk) begin
        if (rst) begin
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            if (tmo_hit)        err_timeout <= 1'b1;
            else if (clear_err) err_timeout <= 1'b0;
            if (spurious)       err_spurious <= 1'b1;
            else if (clear_err) err_spurious <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ci_issuer.sv
// tb_ci_issuer: randomized bench for ci_issuer against a queue model.
// Includes a latency-13 slave and a second instance with ISSUE_GAP=3.
module tb_ci_issuer;

    localparam int MAXO  = 4;
    localparam int DEPTH = 4;
    localparam int GAP   = 1;
    localparam int TMO   = 64;
    localparam int LAT   = 13;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [1:0]  req_n = '0;
    logic        ci_clk_en, ci_start;
    logic [31:0] ci_dataa, ci_datab;
    logic [1:0]  ci_n;
    logic [31:0] ci_result = '0;
    logic        ci_done = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_n;
    logic [2:0]  outstanding;
    logic        err_timeout, err_spurious;
    logic        clear_err = 1'b0;

    logic        drop_done  = 1'b0;
    logic        force_done = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_acc   = 0;
    int n_pop   = 0;
    logic [1:0] pop_log[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ci_issuer #(
        .MAX_OUTSTANDING(MAXO), .RSP_DEPTH(DEPTH),
        .ISSUE_GAP(GAP), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_n(req_n),
        .ci_clk_en(ci_clk_en), .ci_start(ci_start),
        .ci_dataa(ci_dataa), .ci_datab(ci_datab), .ci_n(ci_n),
        .ci_result(ci_result), .ci_done(ci_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_n(rsp_n),
        .outstanding(outstanding),
        .err_timeout(err_timeout), .err_spurious(err_spurious),
        .clear_err(clear_err)
    );

    // Second instance: issue spacing with req_valid held high
    logic        g_ready, g_clk_en, g_start, g_rsp_valid;
    logic        g_etmo, g_espu;
    logic [31:0] g_dataa, g_datab, g_rsp_data;
    logic [1:0]  g_n, g_rsp_n;
    logic [2:0]  g_out;
    int          g_t[4];
    int          g_seen = 0;

    ci_issuer #(
        .MAX_OUTSTANDING(MAXO), .RSP_DEPTH(DEPTH),
        .ISSUE_GAP(3), .TIMEOUT(TMO)
    ) dut_gap (
        .clk(clk), .rst(rst),
        .req_valid(1'b1), .req_ready(g_ready),
        .req_a(32'h3F800000), .req_b(32'h40000000), .req_n(2'd3),
        .ci_clk_en(g_clk_en), .ci_start(g_start),
        .ci_dataa(g_dataa), .ci_datab(g_datab), .ci_n(g_n),
        .ci_result(32'h0), .ci_done(1'b0),
        .rsp_valid(g_rsp_valid), .rsp_ready(1'b0),
        .rsp_data(g_rsp_data), .rsp_n(g_rsp_n),
        .outstanding(g_out),
        .err_timeout(g_etmo), .err_spurious(g_espu),
        .clear_err(1'b0)
    );

    always @(negedge clk) begin
        if (!rst && g_start && g_seen < 4) begin
            g_t[g_seen] = cyc;
            g_seen++;
        end
    end

    task automatic check(input string tag,
                         input logic [95:0] got,
                         input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] slave_fn(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [1:0]  n);
        return (a ^ {b[15:0], b[31:16]}) + {30'd0, n};
    endfunction

    // Slave: fixed-latency pipeline, one done per start, never stalls
    int          sq_due[$];
    logic [31:0] sq_res[$];

    always begin
        @(posedge clk);
        #2;
        ci_done   = 1'b0;
        ci_result = '0;
        if (sq_due.size() != 0 && sq_due[0] == cyc) begin
            ci_done   = !drop_done;
            ci_result = sq_res[0];
            void'(sq_due.pop_front());
            void'(sq_res.pop_front());
        end
        if (force_done) begin
            ci_done   = 1'b1;
            ci_result = 32'hDEADBEEF;
        end
        if (ci_start) begin
            sq_due.push_back(cyc + LAT);
            sq_res.push_back(slave_fn(ci_dataa, ci_datab, ci_n));
        end
    end

    // Reference model: in-flight queue and response queue
    int          m_mode;
    logic [33:0] m_infl[$];
    logic [33:0] m_fifo[$];
    logic        m_etmo, m_espu, m_start;
    logic [65:0] m_ops;
    int          m_idle, m_since;
    bit          started = 1'b0;

    always @(negedge clk) begin : model
        bit rdy, hs, dacc, spur, pop, qual, tmo;
        int ni, nf;
        ni  = m_infl.size();
        nf  = m_fifo.size();
        rdy = (m_mode == 1) && ni < MAXO
            && (ni + nf) < DEPTH && m_since >= GAP;
        if (started) begin
            check("clk_en", ci_clk_en, m_mode != 0);
            check("req_ready", req_ready, rdy);
            check("start", ci_start, m_start);
            check("ops", {ci_n, ci_dataa, ci_datab}, m_ops);
            check("outstanding", outstanding, ni);
            check("rsp_valid", rsp_valid, nf != 0);
            if (nf != 0) check("rsp", {rsp_n, rsp_data}, m_fifo[0]);
            check("err_timeout", err_timeout, m_etmo);
            check("err_spurious", err_spurious, m_espu);
        end
        if (rst) begin
            started = 1'b1;
            m_mode  = 0;
            m_infl.delete();
            m_fifo.delete();
            m_etmo  = 1'b0;
            m_espu  = 1'b0;
            m_start = 1'b0;
            m_ops   = '0;
            m_idle  = 0;
            m_since = GAP;
        end else if (started) begin
            hs   = req_valid && rdy;
            dacc = ci_done && ni != 0 && m_mode != 2;
            spur = ci_done && ni == 0 && m_mode != 2;
            pop  = nf != 0 && rsp_ready;
            qual = m_mode == 1 && ni != 0 && !hs && !dacc;
            tmo  = qual && m_idle == TMO - 1;
            m_idle = (qual && !tmo) ? m_idle + 1 : 0;
            if (pop) begin
                pop_log.push_back(m_fifo[0][33:32]);
                void'(m_fifo.pop_front());
                n_pop++;
            end
            if (dacc) begin
                m_fifo.push_back(m_infl[0]);
                void'(m_infl.pop_front());
            end
            if (hs) begin
                m_infl.push_back({req_n, slave_fn(req_a, req_b, req_n)});
                m_ops = {req_n, req_a, req_b};
                n_acc++;
            end
            m_start = hs;
            if (hs) m_since = 1;
            else if (m_since < 1000) m_since++;
            if (spur) m_espu = 1'b1;
            else if (clear_err) m_espu = 1'b0;
            if (tmo) m_etmo = 1'b1;
            else if (clear_err) m_etmo = 1'b0;
            if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1 && tmo) begin
                m_mode = 2;
            end else if (m_mode == 2 && clear_err) begin
                m_mode = 1;
                m_infl.delete();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] n, input int budget,
                        output bit ok);
        req_a = a;
        req_b = b;
        req_n = n;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
            tick();
        end
        req_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit ok;
        int cnt, a0, p0;

        repeat (3) tick();
        check("rst_clk_en", ci_clk_en, 1'b0);
        check("rst_ready", req_ready, 1'b0);
        check("rst_dataa", ci_dataa, 32'h0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_out", outstanding, 3'd0);
        rst = 1'b0;
        tick();
        check("init_clk_en", ci_clk_en, 1'b1);

        // single op and its latency
        send(32'h40A00000, 32'h41200000, 2'd1, 20, ok);
        check("single_acc", ok, 1'b1);
        check("single_start", ci_start, 1'b1);
        check("single_dataa", ci_dataa, 32'h40A00000);
        cnt = 0;
        while (!rsp_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        check("single_lat", cnt, 14);
        check("single_n", rsp_n, 2'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("single_out", outstanding, 3'd0);

        // two ops 13 clocks apart, returned in order
        pop_log.delete();
        p0 = n_pop;
        rsp_ready = 1'b1;
        send(32'h40A00000, 32'h41200000, 2'd1, 20, ok);
        repeat (12) tick();
        send(32'h41700000, 32'h41A00000, 2'd2, 20, ok);
        cnt = 0;
        while (n_pop - p0 < 2 && cnt < 60) begin
            tick();
            cnt++;
        end
        check("two_cnt", n_pop - p0, 2);
        check("two_n0", pop_log.size() > 0 ? pop_log[0] : 2'd0, 2'd1);
        check("two_n1", pop_log.size() > 1 ? pop_log[1] : 2'd0, 2'd2);
        rsp_ready = 1'b0;

        // backpressure: 6 back-to-back requests, 4 credits
        a0 = n_acc;
        p0 = n_pop;
        for (int i = 0; i < 6; i++)
            send($urandom, $urandom, 2'(i), 3, ok);
        check("bp_acc", n_acc - a0, 4);
        repeat (20) tick();
        check("bp_ready_full", req_ready, 1'b0);
        check("bp_rsp_valid", rsp_valid, 1'b1);
        rsp_ready = 1'b1;
        repeat (8) tick();
        rsp_ready = 1'b0;
        check("bp_drain", n_pop - p0, 4);

        // dropped done -> timeout, then recovery
        drop_done = 1'b1;
        send(32'h3F800000, 32'h3F800000, 2'd0, 20, ok);
        repeat (50) tick();
        check("tmo_early", err_timeout, 1'b0);
        repeat (20) tick();
        check("tmo_flag", err_timeout, 1'b1);
        check("tmo_ready", req_ready, 1'b0);
        drop_done = 1'b0;
        pulse_clear();
        check("clr_out", outstanding, 3'd0);
        check("clr_flag", err_timeout, 1'b0);
        check("clr_ready", req_ready, 1'b1);
        send(32'h40400000, 32'h40800000, 2'd3, 20, ok);
        cnt = 0;
        while (!rsp_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        check("clr_rsp", rsp_valid, 1'b1);
        check("clr_rsp_n", rsp_n, 2'd3);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // done with nothing outstanding
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        tick();
        check("spur_flag", err_spurious, 1'b1);
        check("spur_rsp", rsp_valid, 1'b0);
        pulse_clear();
        check("spur_clr", err_spurious, 1'b0);

        // reset with ops in flight
        send($urandom, $urandom, 2'd1, 5, ok);
        send($urandom, $urandom, 2'd2, 5, ok);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("mid_clk_en", ci_clk_en, 1'b0);
        check("mid_start", ci_start, 1'b0);
        check("mid_dataa", ci_dataa, 32'h0);
        check("mid_out", outstanding, 3'd0);
        check("mid_ready", req_ready, 1'b0);
        rst = 1'b0;
        repeat (25) tick();
        check("late_spur", err_spurious, 1'b1);
        check("late_rsp", rsp_valid, 1'b0);
        pulse_clear();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            req_valid = ($urandom_range(0, 9) < 6);
            req_a     = $urandom;
            req_b     = $urandom;
            req_n     = 2'($urandom_range(0, 3));
            rsp_ready = $urandom_range(0, 1) == 1;
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (40) tick();
        check("end_out", outstanding, 3'd0);
        check("end_rsp", rsp_valid, 1'b0);
        check("end_tmo", err_timeout, 1'b0);

        // spacing of the ISSUE_GAP=3 instance
        check("gap_seen", g_seen, 4);
        for (int i = 0; i < 3; i++)
            check("gap_dist", g_t[i + 1] - g_t[i], 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
